// File: rtl/power_ramp_if.sv
// Command handshake into the power ramp: target power and direction.
interface power_ramp_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_power;
  logic       cmd_dir;

  modport master (output cmd_valid, cmd_power, cmd_dir, input cmd_ready);
  modport slave  (input  cmd_valid, cmd_power, cmd_dir, output cmd_ready);
endinterface

// File: rtl/power_ramp.sv
// Slew-rate-limited power/direction command stage feeding the motor PWM.
// Power steps toward the target once per tick; direction reversals ramp to
// zero, hold a dead time, flip dir, then ramp up. Brake forces zero at once.
module power_ramp #(
  parameter int TICK_DIV       = 50000,
  parameter int STEP           = 1,
  parameter int DEADTIME_TICKS = 10
) (
  input  logic           clock,
  input  logic           reset,
  power_ramp_if.slave    cmd,
  input  logic           brake,
  output logic [7:0]     power,
  output logic           dir,
  output logic           at_target,
  output logic           busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DEADTIME_TICKS > 1) ? $clog2(DEADTIME_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DEADTIME_TICKS - 1);
  localparam logic [8:0]    STEP9      = 9'(STEP);
  localparam logic [7:0]    STEP8      = 8'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, REV_DOWN, DWELL} state_t;

  state_t        state_q, state_d;
  logic [7:0]    power_q, power_d;
  logic [7:0]    target_q, target_d;
  logic          dir_q, dir_d;
  logic          tgt_dir_q, tgt_dir_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

  logic       tick;
  logic       accept;
  logic [7:0] ramp_next;
  logic [7:0] down_next;
  logic [8:0] gap;

  assign tick          = (tick_cnt_q == TICK_LAST);
  assign cmd.cmd_ready = ((state_q == IDLE) || (state_q == RAMP)) && !brake && !reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign power     = power_q;
  assign dir       = dir_q;
  assign at_target = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // One ramp step toward target in 9-bit arithmetic: clamp at the target
  // when the remaining gap is no larger than STEP, so it never overshoots or wraps.
  always_comb begin
    if (power_q < target_q) begin
      gap       = {1'b0, target_q} - {1'b0, power_q};
      ramp_next = (gap <= STEP9) ? target_q : power_q + STEP8;
    end else begin
      gap       = {1'b0, power_q} - {1'b0, target_q};
      ramp_next = (gap <= STEP9) ? target_q : power_q - STEP8;
    end
    down_next = ({1'b0, power_q} <= STEP9) ? 8'd0 : power_q - STEP8;
  end

  // Next-state: brake over accept over tick; an accept swallows a coincident tick.
  always_comb begin
    state_d     = state_q;
    power_d     = power_q;
    target_d    = target_q;
    dir_d       = dir_q;
    tgt_dir_d   = tgt_dir_q;
    dwell_cnt_d = dwell_cnt_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);

    if (brake) begin
      power_d  = '0;
      target_d = '0;
      state_d  = IDLE;
    end else if (accept) begin
      target_d  = cmd.cmd_power;
      tgt_dir_d = cmd.cmd_dir;
      if (cmd.cmd_dir == dir_q) begin
        state_d = (cmd.cmd_power != power_q) ? RAMP : IDLE;
      end else if (power_q == '0) begin
        // Already stopped: flip immediately, no dead time needed.
        dir_d   = cmd.cmd_dir;
        state_d = (cmd.cmd_power != '0) ? RAMP : IDLE;
      end else begin
        state_d = REV_DOWN;
      end
    end else if (tick) begin
      unique case (state_q)
        RAMP: begin
          power_d = ramp_next;
          if (ramp_next == target_q) state_d = IDLE;
        end
        REV_DOWN: begin
          power_d = down_next;
          if (down_next == '0) begin
            state_d     = DWELL;
            dwell_cnt_d = '0;
          end
        end
        DWELL: begin
          dwell_cnt_d = dwell_cnt_q + DW'(1);
          if (dwell_cnt_q == DWELL_LAST) begin
            dir_d   = tgt_dir_q;
            state_d = (target_q != '0) ? RAMP : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset that overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      power_q     <= '0;
      target_q    <= '0;
      dir_q       <= 1'b0;
      tgt_dir_q   <= 1'b0;
      tick_cnt_q  <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      power_q     <= power_d;
      target_q    <= target_d;
      dir_q       <= dir_d;
      tgt_dir_q   <= tgt_dir_d;
      tick_cnt_q  <= tick_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

endmodule
